// File: rtl/morph_pkg.sv
// Shared definitions for the morphological closing pass sequencer.
package morph_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_SWAP  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_DRAIN = ST_DRAIN,
    S_SWAP  = ST_SWAP,
    S_FIN   = ST_FIN
  } state_e;

  // Output mux select for the window datapath
  localparam logic OP_DILATE = 1'b0;
  localparam logic OP_ERODE  = 1'b1;

  // Pixel count of one frame
  function automatic int unsigned frame_size(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  localparam int unsigned DEF_PIC_WIDTH  = 250;
  localparam int unsigned DEF_PIC_HEIGHT = 250;
  localparam int unsigned DEF_FRAME_PIX  = frame_size(DEF_PIC_WIDTH, DEF_PIC_HEIGHT);

endpackage

// File: rtl/morph_pass_ctrl_delay_line.sv
// 1-bit shift register with synchronous clear; exposes an intermediate tap
// and the final stage. TAP must be in 1..DEPTH.
module morph_delay_line #(
  parameter int DEPTH = 4,
  parameter int TAP   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic tap_out,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Next shift-register contents: shift in din, or flush on clear
  always_comb begin
    sr_d = '0;
    if (!clr) begin
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tap_out = sr_q[TAP-1];
  assign dout    = sr_q[DEPTH-1];

endmodule

// File: rtl/morph_pass_ctrl.sv
// Closing-run sequencer: N dilate passes then N erode passes over a
// ping-pong frame buffer, with latency-aligned write-back.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; counters hold their last values
// READ  | one raster read per cycle from the source bank
// DRAIN | reads stopped, waiting for the last write of the pass
// SWAP  | flip banks, advance pass, rewind address counters
// FIN   | one-cycle done pulse, then back to IDLE
module morph_pass_ctrl
  import morph_pkg::*;
#(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int PIPE_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        iters,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              src_bank,
  output logic              win_valid,
  output logic              op_sel,
  output logic [4:0]        pass_idx
);

  localparam int unsigned       FRAME     = frame_size(PIC_WIDTH, PIC_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
  localparam int                DLY       = RD_LAT + PIPE_LAT;

  state_e            state_q, state_d;
  logic [3:0]        iters_q, iters_d;
  logic [4:0]        pass_idx_q, pass_idx_d;
  logic              src_bank_q, src_bank_d;
  logic              op_sel_q, op_sel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [4:0]        last_pass;
  logic              dly_clr;
  logic              wr_en_w;
  logic              win_valid_w;

  assign last_pass = {iters_q, 1'b0} - 5'd1;

  // Next-state and next-counter logic; abort overrides every transition
  always_comb begin
    state_d    = state_q;
    iters_d    = iters_q;
    pass_idx_d = pass_idx_q;
    src_bank_d = src_bank_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      // write address follows issued writes, parked at the last pixel
      if (wr_en_w && (wr_addr_q != LAST_ADDR)) begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            iters_d    = iters;
            pass_idx_d = '0;
            src_bank_d = 1'b0;
            rd_addr_d  = '0;
            wr_addr_d  = '0;
            state_d    = (iters == 4'd0) ? S_FIN : S_READ;
          end
        end
        S_READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (wr_en_w && (wr_addr_q == LAST_ADDR)) begin
            state_d = S_SWAP;
          end
        end
        S_SWAP: begin
          src_bank_d = ~src_bank_q;
          pass_idx_d = pass_idx_q + 5'd1;
          rd_addr_d  = '0;
          wr_addr_d  = '0;
          state_d    = (pass_idx_q == last_pass) ? S_FIN : S_READ;
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    rd_en_d = (state_d == S_READ);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    // a zero-iteration run has no passes, so it never selects erode
    op_sel_d = (iters_d != 4'd0) && ({1'b0, iters_d} <= pass_idx_d) ? OP_ERODE : OP_DILATE;
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iters_q    <= '0;
      pass_idx_q <= '0;
      src_bank_q <= 1'b0;
      op_sel_q   <= OP_DILATE;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iters_q    <= iters_d;
      pass_idx_q <= pass_idx_d;
      src_bank_q <= src_bank_d;
      op_sel_q   <= op_sel_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Flushing at SWAP/FIN guarantees a clean gap in win_valid between passes;
  // flushing on abort discards in-flight writes.
  assign dly_clr = abort || (state_q == S_SWAP) || (state_q == S_FIN);

  morph_delay_line #(
    .DEPTH (DLY),
    .TAP   (RD_LAT)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (dly_clr),
    .din     (rd_en_q),
    .tap_out (win_valid_w),
    .dout    (wr_en_w)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_w;
  assign wr_addr   = wr_addr_q;
  assign src_bank  = src_bank_q;
  assign win_valid = win_valid_w;
  assign op_sel    = op_sel_q;
  assign pass_idx  = pass_idx_q;

endmodule
